muldiv_ctrl: RTL

Sequencing controller for the CPU's multiply/divide resource and owner of the HI/LO registers. Accepts one operation at a time from decode (MULT/MULTU/DIV/DIVU/MTHI/MTLO), runs a 1-cycle registered multiplier or a 32-iteration divider, then writes HI/LO. It exposes write-port and read values so decode can forward and stall.

---
 rtl/muldiv_pkg.sv | 38 +++
 rtl/muldiv_div_core.sv | 51 +++++
 rtl/muldiv_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | muldiv_pkg : op codes, FSM encoding and helpers for muldiv_ctrl   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package muldiv_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  localparam int DIV_ITER = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

  // Codes 6 and 7 are reserved and write neither register.
  function automatic logic writes_hi(input logic [2:0] op);
    return (op <= MD_MTHI);
  endfunction

  function automatic logic writes_lo(input logic [2:0] op);
    return (op <= MD_DIVU) || (op == MD_MTLO);
  endfunction

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_div_core.sv
`default_nettype none
// +------------------------------------------------------------------+
// | div_core : restoring divider, one quotient bit per step on        |
// | unsigned 32-bit magnitudes.  Rev 1.0                              |
// +------------------------------------------------------------------+
module div_core (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_start,
  input  logic        i_step,
  input  logic [31:0] i_dividend,
  input  logic [31:0] i_divisor,
  output logic [31:0] o_quot,
  output logic [31:0] o_rem
);

  logic [31:0] r_q;
  logic [31:0] r_r;
  logic [31:0] r_d;
  logic [32:0] w_sh;
  logic [32:0] w_diff;

  // Dividend shifts out of r_q's top while quotient bits shift in below.
  assign w_sh   = {r_r, r_q[31]};
  assign w_diff = w_sh - {1'b0, r_d};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_q <= '0;
      r_r <= '0;
      r_d <= '0;
    end else if (i_start) begin
      r_q <= i_dividend;
      r_r <= '0;
      r_d <= i_divisor;
    end else if (i_step) begin
      if (!w_diff[32]) begin
        r_r <= w_diff[31:0];
        r_q <= {r_q[30:0], 1'b1};
      end else begin
        r_r <= w_sh[31:0];
        r_q <= {r_q[30:0], 1'b0};
      end
    end
  end

  assign o_quot = r_q;
  assign o_rem  = r_r;

endmodule
`default_nettype wire

// File: rtl/muldiv_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | muldiv_ctrl : multiply/divide sequencer and HI/LO owner.          |
// | MULDIV_DIV0_FAST_EN: divide-by-zero bypasses iterations. Rev 1.0  |
// +------------------------------------------------------------------+
module muldiv_ctrl
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_x,
  input  logic [31:0] req_y,
  input  logic        cancel,
  output logic        busy,
  output logic        complete,
  output logic        hi_wen,
  output logic        lo_wen,
  output logic [31:0] hi_wdata,
  output logic [31:0] lo_wdata,
  output logic [31:0] hi_rdata,
  output logic [31:0] lo_rdata
);

  localparam logic [4:0] c_LAST_ITER = 5'(DIV_ITER - 1);

  state_t      r_state;
  logic [2:0]  r_op;
  logic [31:0] r_x;
  logic [31:0] r_y;
  logic [4:0]  r_cnt;
  logic [63:0] r_prod;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_complete;
  logic        r_hi_wen;
  logic        r_lo_wen;

  logic        w_accept;
  logic        w_is_div_req;
  logic        w_signed_req;
  logic        w_div_step;
  logic [31:0] w_dividend;
  logic [31:0] w_divisor;
  logic [31:0] w_core_q;
  logic [31:0] w_core_r;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_q_fix;
  logic [31:0] w_r_fix;
  logic [63:0] w_smul;
  logic [63:0] w_umul;
  logic [31:0] w_hi_res;
  logic [31:0] w_lo_res;

  assign w_accept     = req_valid && !cancel && (r_state == ST_IDLE);
  assign w_is_div_req = (req_op == MD_DIV) || (req_op == MD_DIVU);
  assign w_signed_req = (req_op == MD_DIV);
  assign w_div_step   = (r_state == ST_DIV) && !cancel;
  assign w_dividend   = w_signed_req ? abs32(req_x) : req_x;
  assign w_divisor    = w_signed_req ? abs32(req_y) : req_y;

  div_core u_div_core (
    .clk        (clk),
    .resetn     (resetn),
    .i_start    (w_accept && w_is_div_req),
    .i_step     (w_div_step),
    .i_dividend (w_dividend),
    .i_divisor  (w_divisor),
    .o_quot     (w_core_q),
    .o_rem      (w_core_r)
  );

`ifdef MULDIV_DIV0_FAST_EN
  logic r_fast;
  assign w_q_mag = r_fast ? 32'hFFFF_FFFF : w_core_q;
  assign w_r_mag = r_fast ? ((r_op == MD_DIV) ? abs32(r_x) : r_x) : w_core_r;
`else
  assign w_q_mag = w_core_q;
  assign w_r_mag = w_core_r;
`endif

  assign w_q_fix = ((r_op == MD_DIV) && (r_x[31] ^ r_y[31])) ? (~w_q_mag + 32'd1) : w_q_mag;
  assign w_r_fix = ((r_op == MD_DIV) && r_x[31]) ? (~w_r_mag + 32'd1) : w_r_mag;

  // Sign-extended 64x64 multiply: the low 64 bits equal the signed product.
  assign w_smul = {{32{r_x[31]}}, r_x} * {{32{r_y[31]}}, r_y};
  assign w_umul = {32'd0, r_x} * {32'd0, r_y};

  always_comb begin
    w_hi_res = '0;
    w_lo_res = '0;
    case (r_op)
      MD_MULT, MD_MULTU: begin
        w_hi_res = r_prod[63:32];
        w_lo_res = r_prod[31:0];
      end
      MD_DIV, MD_DIVU: begin
        w_hi_res = w_r_fix;
        w_lo_res = w_q_fix;
      end
      MD_MTHI: w_hi_res = r_x;
      MD_MTLO: w_lo_res = r_x;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= ST_IDLE;
      r_op       <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_cnt      <= '0;
      r_prod     <= '0;
      r_complete <= 1'b0;
      r_hi_wen   <= 1'b0;
      r_lo_wen   <= 1'b0;
`ifdef MULDIV_DIV0_FAST_EN
      r_fast     <= 1'b0;
`endif
    end else begin
      r_complete <= 1'b0;
      r_hi_wen   <= 1'b0;
      r_lo_wen   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op  <= req_op;
            r_x   <= req_x;
            r_y   <= req_y;
            r_cnt <= '0;
`ifdef MULDIV_DIV0_FAST_EN
            r_fast <= 1'b0;
`endif
            if ((req_op == MD_MULT) || (req_op == MD_MULTU)) begin
              r_state <= ST_MUL;
            end else if (w_is_div_req) begin
`ifdef MULDIV_DIV0_FAST_EN
              if (req_y == 32'd0) begin
                r_fast     <= 1'b1;
                r_state    <= ST_FIN;
                r_complete <= 1'b1;
                r_hi_wen   <= 1'b1;
                r_lo_wen   <= 1'b1;
              end else begin
                r_state <= ST_DIV;
              end
`else
              r_state <= ST_DIV;
`endif
            end else begin
              r_state    <= ST_FIN;
              r_complete <= 1'b1;
              r_hi_wen   <= writes_hi(req_op);
              r_lo_wen   <= writes_lo(req_op);
            end
          end
        end
        ST_MUL: begin
          if (cancel) begin
            r_state <= ST_IDLE;
          end else begin
            r_prod     <= (r_op == MD_MULT) ? w_smul : w_umul;
            r_state    <= ST_FIN;
            r_complete <= 1'b1;
            r_hi_wen   <= 1'b1;
            r_lo_wen   <= 1'b1;
          end
        end
        ST_DIV: begin
          if (cancel) begin
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == c_LAST_ITER) begin
              r_state    <= ST_FIN;
              r_complete <= 1'b1;
              r_hi_wen   <= 1'b1;
              r_lo_wen   <= 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // A flush arriving during FIN still has to kill the write in that cycle.
  assign complete  = r_complete & ~cancel;
  assign hi_wen    = r_hi_wen & ~cancel;
  assign lo_wen    = r_lo_wen & ~cancel;
  assign hi_wdata  = hi_wen ? w_hi_res : 32'd0;
  assign lo_wdata  = lo_wen ? w_lo_res : 32'd0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      if (hi_wen) r_hi <= hi_wdata;
      if (lo_wen) r_lo <= lo_wdata;
    end
  end

  assign hi_rdata  = r_hi;
  assign lo_rdata  = r_lo;
  assign busy      = (r_state != ST_IDLE);
  assign req_ready = (r_state == ST_IDLE);

endmodule
`default_nettype wire
